usb_token_crc5_ctrl: RTL and testbench
======================================

Name: usb_token_crc5_ctrl

Overview:
- Sequences the serial CRC5 engine for incoming USB token packets (OUT/IN/SETUP/SOF) on the endpoint's receive path.
- Sits after the PID decoder and bit-unstuffer.
- Captures the 11-bit field (ADDR[6:0] + ENDP[3:0], or frame number) and then the 5 CRC bits.
- Drives the CRC engine's reset and shift strobes, checks the residual, and reports a one-cycle verdict with the captured fields.

Parameters:
- FIELD_BITS, 11, payload bits covered by CRC5
- CRC_BITS, 5, CRC bits following the field
- CRC_RESIDUAL, 5'b01100, required remainder after field plus received CRC

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pkt_start  in  1  pulse: token PID accepted; next bit_valid is field bit 0
- bit_valid  in  1  rx_bit valid this cycle (unstuffed, NRZI-decoded)
- rx_bit  in  1  received bit, LSB first
- eop  in  1  pulse: end of packet detected
- addr  out  7  captured device address
- endp  out  4  captured endpoint number
- field  out  11  full captured field (frame number for SOF)
- token_ok  out  1  one-cycle pulse: 16 bits received, residual matched
- crc_err  out  1  one-cycle pulse: 16 bits received, residual mismatch
- len_err  out  1  one-cycle pulse: EOP before 16 bits or more than 16 bits
- busy  out  1  high from pkt_start until the verdict cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; bit counter 0; CRC register 5'b11111.
- States are IDLE, FIELD, CRC, WAIT_EOP and REPORT.
- IDLE:
  - pkt_start -> FIELD.
  - Same cycle: CRC register loaded to 5'b11111, counter cleared, field cleared.
- FIELD:
  - Each bit_valid shifts rx_bit into field[cnt], updates the CRC, and increments cnt.
  - After the 11th bit -> CRC with cnt=0.
- CRC:
  - Each bit_valid updates the CRC only; field is not changed.
  - After the 5th bit -> WAIT_EOP.
- CRC update, per valid bit: fb = rx_bit ^ crc[4]; crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 0).
- WAIT_EOP:
  - eop -> REPORT with verdict = (crc == CRC_RESIDUAL).
  - A further bit_valid before eop sets an overflow flag.
- REPORT:
  - Lasts exactly one cycle and asserts exactly one of token_ok, crc_err, len_err.
  - Overflow takes precedence, giving len_err.
  - Then -> IDLE.
- Latency: verdict pulse appears the cycle after eop is sampled.
- addr = field[6:0] and endp = field[10:7]. They are registered, valid from REPORT onward, and held until the next pkt_start.
- eop in FIELD or CRC (short packet) -> REPORT with len_err.
- bit_valid and eop in the same cycle: the bit is consumed first, then eop is evaluated with the updated count.
- pkt_start in any non-IDLE state: abort silently with no verdict pulse, and restart FIELD with a fresh CRC init.
- bit_valid in IDLE: ignored.
- eop in IDLE: ignored.
- Asynchronous rst mid-packet returns to reset values immediately. No verdict is emitted for the aborted packet.
- busy is 1 in FIELD, CRC, WAIT_EOP and REPORT.

Decomposition:
- Shared usb_pkg holds:
  - the state enum token_state_t;
  - constants CRC5_INIT=5'b11111, CRC5_POLY=5'b00101, CRC5_RESIDUAL=5'b01100;
  - TOKEN_FIELD_BITS=11.
- One sub-module, usb_crc5_serial: clk, rst, init, shift_en, din, crc[4:0].
  - The controller drives init on pkt_start and shift_en on valid bits in FIELD and CRC.
  - The controller itself owns only the FSM, counter and capture.

Test Plan:
- Good token, ADDR=0x15, ENDP=0xE, CRC5=0x17:
  - Stimulus: pkt_start, then 16 bit_valid bits (field LSB first, CRC MSB first, inverted per USB), then eop.
  - Required: token_ok pulse exactly 1 cycle after eop; addr=7'h15, endp=4'hE; busy falls after REPORT.
- Same packet with field bit 3 flipped -> crc_err pulse; token_ok stays 0; addr reflects the corrupted value 7'h1D.
- Short packet, eop after 12 valid bits -> len_err pulse; token_ok=0; crc_err=0.
- Long packet, 17 valid bits then eop -> len_err pulse; crc_err not asserted even if the residual matched after bit 16.
- Abort paths:
  - pkt_start after 7 bits, then a full good 0x15/0xE token -> one token_ok only.
  - rst asserted at bit 9 -> outputs 0 immediately, no pulses.
- Gapped stream: good token with bit_valid low for 0–3 random cycles between bits, plus bit 16 coincident with eop -> token_ok; the result is identical to the ungapped case.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types, CRC5 constants and step function for USB token checking
package usb_pkg;

  localparam int TOKEN_FIELD_BITS = 11;
  localparam int TOKEN_CRC_BITS   = 5;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIELD,
    ST_CRC,
    ST_WAIT_EOP,
    ST_REPORT
  } token_state_t;

  // One serial CRC5 step; shared so the controller can look ahead on the final bit.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

endpackage

// File: rtl/usb_token_crc5_ctrl_if.sv
// rtl/usb_token_crc5_ctrl_if.sv - bit stream in, captured token fields and verdict out
interface usb_token_crc5_ctrl_if;
  import usb_pkg::*;

  logic                        pkt_start;
  logic                        bit_valid;
  logic                        rx_bit;
  logic                        eop;
  logic [6:0]                  addr;
  logic [3:0]                  endp;
  logic [TOKEN_FIELD_BITS-1:0] field;
  logic                        token_ok;
  logic                        crc_err;
  logic                        len_err;
  logic                        busy;

  modport master (
    output pkt_start, bit_valid, rx_bit, eop,
    input  addr, endp, field, token_ok, crc_err, len_err, busy
  );

  modport slave (
    input  pkt_start, bit_valid, rx_bit, eop,
    output addr, endp, field, token_ok, crc_err, len_err, busy
  );

endinterface

// File: rtl/usb_crc5_serial.sv
// rtl/usb_crc5_serial.sv - serial CRC5 engine, LSB-first input, init has priority over shift
module usb_crc5_serial
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       shift_en,
  input  logic       din,
  output logic [4:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC5_INIT;
    end else if (init) begin
      crc <= CRC5_INIT;
    end else if (shift_en) begin
      crc <= crc5_next(crc, din);
    end
  end

endmodule

// File: rtl/usb_token_crc5_ctrl.sv
// rtl/usb_token_crc5_ctrl.sv - token field capture, CRC5 sequencing and one-cycle verdict
module usb_token_crc5_ctrl
  import usb_pkg::*;
#(
  parameter int         FIELD_BITS   = TOKEN_FIELD_BITS,
  parameter int         CRC_BITS     = TOKEN_CRC_BITS,
  parameter logic [4:0] CRC_RESIDUAL = CRC5_RESIDUAL
) (
  input logic                  clk,
  input logic                  rst,
  usb_token_crc5_ctrl_if.slave tok
);

  token_state_t                state;
  logic [3:0]                  cnt;
  logic                        overflow;
  logic [TOKEN_FIELD_BITS-1:0] field_q;
  logic [TOKEN_FIELD_BITS-1:0] field_upd;
  logic [6:0]                  addr_q;
  logic [3:0]                  endp_q;
  logic                        token_ok_q;
  logic                        crc_err_q;
  logic                        len_err_q;
  logic                        busy_q;
  logic                        shift_en;
  logic [4:0]                  crc;
  logic [4:0]                  crc_upd;
  logic                        last_crc_bit;

  // A restart wins over a coincident bit, so that bit never reaches the fresh CRC.
  assign shift_en     = tok.bit_valid && !tok.pkt_start &&
                        (state == ST_FIELD || state == ST_CRC);
  assign crc_upd      = shift_en ? crc5_next(crc, tok.rx_bit) : crc;
  assign last_crc_bit = shift_en && (state == ST_CRC) && (cnt == 4'(CRC_BITS - 1));

  always_comb begin
    field_upd = field_q;
    if (shift_en && state == ST_FIELD) begin
      field_upd[cnt] = tok.rx_bit;
    end
  end

  usb_crc5_serial u_crc5 (
    .clk      (clk),
    .rst      (rst),
    .init     (tok.pkt_start),
    .shift_en (shift_en),
    .din      (tok.rx_bit),
    .crc      (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      overflow   <= 1'b0;
      field_q    <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      token_ok_q <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      token_ok_q <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      if (tok.pkt_start) begin
        state    <= ST_FIELD;
        cnt      <= '0;
        overflow <= 1'b0;
        field_q  <= '0;
        addr_q   <= '0;
        endp_q   <= '0;
        busy_q   <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_FIELD: begin
            field_q <= field_upd;
            if (shift_en) begin
              cnt <= cnt + 4'd1;
            end
            // Any EOP here is short, even one arriving with the 11th bit.
            if (tok.eop) begin
              state     <= ST_REPORT;
              len_err_q <= 1'b1;
              addr_q    <= field_upd[6:0];
              endp_q    <= field_upd[10:7];
            end else if (shift_en && cnt == 4'(FIELD_BITS - 1)) begin
              state <= ST_CRC;
              cnt   <= '0;
            end
          end
          ST_CRC: begin
            if (shift_en) begin
              cnt <= cnt + 4'd1;
            end
            if (last_crc_bit) begin
              cnt <= '0;
              if (tok.eop) begin
                state      <= ST_REPORT;
                token_ok_q <= (crc_upd == CRC_RESIDUAL);
                crc_err_q  <= (crc_upd != CRC_RESIDUAL);
                addr_q     <= field_q[6:0];
                endp_q     <= field_q[10:7];
              end else begin
                state <= ST_WAIT_EOP;
              end
            end else if (tok.eop) begin
              state     <= ST_REPORT;
              len_err_q <= 1'b1;
              addr_q    <= field_q[6:0];
              endp_q    <= field_q[10:7];
            end
          end
          ST_WAIT_EOP: begin
            if (tok.eop) begin
              state  <= ST_REPORT;
              addr_q <= field_q[6:0];
              endp_q <= field_q[10:7];
              if (overflow || tok.bit_valid) begin
                len_err_q <= 1'b1;
              end else if (crc == CRC_RESIDUAL) begin
                token_ok_q <= 1'b1;
              end else begin
                crc_err_q <= 1'b1;
              end
            end else if (tok.bit_valid) begin
              overflow <= 1'b1;
            end
          end
          ST_REPORT: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tok.addr     = addr_q;
  assign tok.endp     = endp_q;
  assign tok.field    = field_q;
  assign tok.token_ok = token_ok_q;
  assign tok.crc_err  = crc_err_q;
  assign tok.len_err  = len_err_q;
  assign tok.busy     = busy_q;

endmodule

// File: tb/tb_usb_token_crc5_ctrl.sv
// tb/tb_usb_token_crc5_ctrl.sv - directed checks of token capture, CRC5 verdict and abort paths
module tb_usb_token_crc5_ctrl;

  // Bit i of each word is the i-th bit on the wire: field LSB first, then inverted CRC5 MSB first.
  localparam logic [16:0] GOOD_BITS = 17'h0EF15;  // addr 0x15, endp 0xE, crc5 0x17
  localparam logic [16:0] BAD_BITS  = 17'h0EF1D;  // field bit 3 flipped

  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ok     = 0;
  int   n_crc    = 0;
  int   n_len    = 0;

  usb_token_crc5_ctrl_if tok_if ();

  usb_token_crc5_ctrl dut (
    .clk (tb_clk),
    .rst (rst),
    .tok (tok_if)
  );

  always #5 tb_clk = ~tb_clk;

  always @(negedge tb_clk) begin
    if (tok_if.token_ok === 1'b1) n_ok++;
    if (tok_if.crc_err === 1'b1) n_crc++;
    if (tok_if.len_err === 1'b1) n_len++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic start_pkt();
    tok_if.pkt_start = 1'b1;
    tick();
    tok_if.pkt_start = 1'b0;
  endtask

  task automatic send_bits(input logic [16:0] bits, input int n, input int gap_max, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) tick();
      tok_if.bit_valid = 1'b1;
      tok_if.rx_bit    = bits[i];
      tok_if.eop       = eop_last && (i == n - 1);
      tick();
      tok_if.bit_valid = 1'b0;
      tok_if.eop       = 1'b0;
    end
  endtask

  task automatic send_eop();
    tok_if.eop = 1'b1;
    tick();
    tok_if.eop = 1'b0;
  endtask

  initial begin
    int ok0, crc0, len0;
    tok_if.pkt_start = 1'b0;
    tok_if.bit_valid = 1'b0;
    tok_if.rx_bit    = 1'b0;
    tok_if.eop       = 1'b0;

    repeat (2) tick();
    check("rst_busy", tok_if.busy, 0);
    check("rst_field", tok_if.field, 0);
    check("rst_addr", tok_if.addr, 0);
    check("rst_verdict", {tok_if.token_ok, tok_if.crc_err, tok_if.len_err}, 0);
    rst = 1'b0;
    tick();

    // Stray bits and EOP while idle must be ignored.
    send_bits(GOOD_BITS, 3, 0, 1'b0);
    send_eop();
    tick();
    check("idle_pulses", n_ok + n_crc + n_len, 0);
    check("idle_busy", tok_if.busy, 0);

    // Good token
    start_pkt();
    check("good_busy_start", tok_if.busy, 1);
    send_bits(GOOD_BITS, 16, 0, 1'b0);
    check("good_no_early", tok_if.token_ok, 0);
    send_eop();
    check("good_token_ok", tok_if.token_ok, 1);
    check("good_crc_err", tok_if.crc_err, 0);
    check("good_len_err", tok_if.len_err, 0);
    check("good_addr", tok_if.addr, 7'h15);
    check("good_endp", tok_if.endp, 4'hE);
    check("good_field", tok_if.field, 11'h715);
    check("good_busy_report", tok_if.busy, 1);
    tick();
    check("good_pulse_width", tok_if.token_ok, 0);
    check("good_busy_after", tok_if.busy, 0);
    check("good_addr_held", tok_if.addr, 7'h15);

    // Corrupted field bit 3
    start_pkt();
    send_bits(BAD_BITS, 16, 0, 1'b0);
    send_eop();
    check("bad_crc_err", tok_if.crc_err, 1);
    check("bad_token_ok", tok_if.token_ok, 0);
    check("bad_len_err", tok_if.len_err, 0);
    check("bad_addr", tok_if.addr, 7'h1D);
    tick();

    // Short packet: 12 bits then EOP
    start_pkt();
    send_bits(GOOD_BITS, 12, 0, 1'b0);
    send_eop();
    check("short_len_err", tok_if.len_err, 1);
    check("short_token_ok", tok_if.token_ok, 0);
    check("short_crc_err", tok_if.crc_err, 0);
    tick();

    // Long packet: residual matches after 16 bits, then a 17th bit
    start_pkt();
    send_bits(GOOD_BITS, 17, 0, 1'b0);
    send_eop();
    check("long_len_err", tok_if.len_err, 1);
    check("long_crc_err", tok_if.crc_err, 0);
    check("long_token_ok", tok_if.token_ok, 0);
    tick();

    // Abort after 7 bits, then a full good token
    ok0 = n_ok; crc0 = n_crc; len0 = n_len;
    start_pkt();
    send_bits(BAD_BITS, 7, 0, 1'b0);
    start_pkt();
    send_bits(GOOD_BITS, 16, 0, 1'b0);
    send_eop();
    repeat (2) tick();
    check("abort_ok_count", n_ok - ok0, 1);
    check("abort_err_count", (n_crc - crc0) + (n_len - len0), 0);
    check("abort_addr", tok_if.addr, 7'h15);

    // Asynchronous reset at bit 9
    ok0 = n_ok; crc0 = n_crc; len0 = n_len;
    start_pkt();
    send_bits(GOOD_BITS, 9, 0, 1'b0);
    check("rst_mid_field_pre", tok_if.field, 11'h115);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", tok_if.busy, 0);
    check("rst_mid_field", tok_if.field, 0);
    tick();
    rst = 1'b0;
    send_bits(17'h0EF15 >> 9, 7, 0, 1'b0);
    send_eop();
    repeat (2) tick();
    check("rst_mid_pulses", (n_ok - ok0) + (n_crc - crc0) + (n_len - len0), 0);
    check("rst_mid_busy_after", tok_if.busy, 0);

    // Gapped stream with EOP on the last bit
    start_pkt();
    send_bits(GOOD_BITS, 16, 3, 1'b1);
    check("gap_token_ok", tok_if.token_ok, 1);
    check("gap_errs", {tok_if.crc_err, tok_if.len_err}, 0);
    check("gap_addr", tok_if.addr, 7'h15);
    check("gap_endp", tok_if.endp, 4'hE);
    check("gap_field", tok_if.field, 11'h715);
    tick();
    check("gap_busy_after", tok_if.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
